pqsdn_cam_mgr: RTL
==================

PQSDN_CAM_MGR -- requirements
Module: pqsdn_cam_mgr

Interface
REQ-001 Parameter DATA_W, default 64: CAM entry width in bits.
REQ-002 Parameter ADDR_W, default 6: CAM address width; the CAM has 2**ADDR_W entries.
REQ-003 clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  1  request valid.
REQ-006 req_ready_o  output  1  request accepted on the cycle both req_valid_i and req_ready_o are high.
REQ-007 req_op_i  input  1  operation: 0 = insert, 1 = delete.
REQ-008 req_data_i  input  DATA_W  key to insert.
REQ-009 req_addr_i  input  ADDR_W  slot to delete.
REQ-010 rsp_valid_o  output  1  response valid; held until rsp_ready_i is high.
REQ-011 rsp_ready_i  input  1  response accepted.
REQ-012 rsp_addr_o  output  ADDR_W  allocated, duplicate or deleted slot.
REQ-013 rsp_status_o  output  2  00 = OK, 01 = FULL, 10 = DUP, 11 = ERR.
REQ-014 cam_en_o / cam_wraddr_o / cam_wrdata_o  output  1 / ADDR_W / DATA_W  CAM write port.
REQ-015 cam_rden_o / cam_rddata_o  output  1 / DATA_W  CAM search request.
REQ-016 cam_rdaddr_i / cam_rdvalid_i  input  ADDR_W / 1  CAM search result; combinational from cam_rddata_o.
REQ-017 count_o  output  ADDR_W+1  number of occupied slots.

Function
REQ-018 The block SHALL hold a valid bitmap with one bit per slot; EMPTY = all-ones DATA_W marks a free slot in the CAM.
REQ-019 The state machine SHALL have states INIT, IDLE, SEARCH, WRITE and RESP.
REQ-020 INIT SHALL write EMPTY to addresses 0..2**ADDR_W-1, one per cycle with cam_en_o high, then go to IDLE; req_ready_o SHALL be low throughout INIT.
REQ-021 req_ready_o SHALL be high only in IDLE; an accepted request SHALL be registered and the block SHALL go to SEARCH.
REQ-022 Insert, in SEARCH:
- If req_data_i == EMPTY: status ERR.
- Else if a search hit is returned and the bitmap bit for cam_rdaddr_i is set: status DUP, rsp_addr_o = hit slot.
- Else if all slots are occupied: status FULL, rsp_addr_o = 0.
- Otherwise: allocate the lowest-index free slot and go to WRITE.
REQ-023 Delete, in SEARCH: if the slot's bitmap bit is clear, status ERR; otherwise go to WRITE to write EMPTY to that slot.
REQ-024 WRITE SHALL assert cam_en_o for exactly one cycle, update the bitmap and count_o, set status OK, and go to RESP.
REQ-025 Error, DUP and FULL outcomes SHALL go from SEARCH directly to RESP with no CAM write and no change to the bitmap.
REQ-026 RESP SHALL hold rsp_valid_o and its fields stable until rsp_ready_i is high, then go to IDLE; RESP SHALL last at least one cycle, so a CAM write is visible before the next search.
REQ-027 Latency from acceptance to rsp_valid_o SHALL be 3 cycles for a write and 2 cycles for a reject.
REQ-028 cam_rden_o SHALL be high only in SEARCH for an insert, with cam_rddata_o = the registered key.
REQ-029 count_o SHALL saturate at 2**ADDR_W and never wrap; a delete at count 0 is impossible because the bitmap bit is clear (ERR).

Reset
REQ-030 rst_n low SHALL, asynchronously and at any time including mid-operation, return the block to INIT with:
- bitmap and count_o = 0;
- req_ready_o, rsp_valid_o, cam_en_o and cam_rden_o = 0;
- rsp_addr_o, rsp_status_o, cam_wraddr_o and cam_wrdata_o = 0.
REQ-031 Any in-flight request SHALL be discarded with no response.

Configuration
REQ-032 With macro PQSDN_CAM_MGR_DUP_CHECK_EN defined, the duplicate check of REQ-022 SHALL be performed.
REQ-033 Without PQSDN_CAM_MGR_DUP_CHECK_EN:
- cam_rden_o and cam_rddata_o SHALL be tied to 0;
- cam_rdaddr_i and cam_rdvalid_i SHALL be ignored;
- DUP SHALL never be returned;
- latencies SHALL be unchanged.

Verification
REQ-034 Release reset -> exactly 64 cam_en_o pulses at addresses 0..63 with EMPTY data, then req_ready_o = 1 and count_o = 0.
REQ-035 Insert 0x1111 then 0x2222 -> responses OK at slot 0 then OK at slot 1; count_o = 2.
REQ-036 Insert 0x1111 again (macro defined) -> DUP with rsp_addr_o = 0; no cam_en_o pulse; count_o = 2.
REQ-037 Delete slot 0, then insert 0x3333 -> OK at slot 0, then OK at slot 0; delete slot 5 (free) -> ERR.
REQ-038 Fill all 64 slots, then insert one more key -> FULL; hold rsp_ready_i low for 10 cycles -> rsp_valid_o and its fields held stable.
REQ-039 Assert rst_n low during WRITE -> no response is produced; INIT sweep restarts; count_o = 0.

Source files
------------

// File: rtl/pqsdn_cam_mgr.sv
// CAM slot manager: sweeps the CAM to EMPTY after reset, then serves insert/delete requests
// against a slot-occupancy bitmap. Define PQSDN_CAM_MGR_DUP_CHECK_EN to enable the duplicate-key search.
module pqsdn_cam_mgr #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_op_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic [1:0]        rsp_status_o,
  output logic              cam_en_o,
  output logic [ADDR_W-1:0] cam_wraddr_o,
  output logic [DATA_W-1:0] cam_wrdata_o,
  output logic              cam_rden_o,
  output logic [DATA_W-1:0] cam_rddata_o,
  input  logic [ADDR_W-1:0] cam_rdaddr_i,
  input  logic              cam_rdvalid_i,
  output logic [ADDR_W:0]   count_o
);

  localparam int                NUM_SLOTS = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   INIT_LAST = (ADDR_W + 1)'(NUM_SLOTS);
  localparam logic [DATA_W-1:0] EMPTY     = '1;
  localparam logic              OP_INSERT = 1'b0;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SEARCH,
    S_WRITE,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_FULL = 2'b01,
    ST_DUP  = 2'b10,
    ST_ERR  = 2'b11
  } status_t;

  state_t                state_q, state_d;
  logic [ADDR_W:0]       init_cnt_q;
  logic                  op_q;
  logic [DATA_W-1:0]     key_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [NUM_SLOTS-1:0]  bitmap_q;
  logic [ADDR_W:0]       count_q;
  logic [ADDR_W-1:0]     rsp_addr_q;
  status_t               rsp_status_q;
  logic                  cam_en_q;
  logic [ADDR_W-1:0]     cam_wraddr_q;
  logic [DATA_W-1:0]     cam_wrdata_q;

  logic                  all_full;
  logic [ADDR_W-1:0]     free_idx;
  logic                  dup_hit;
  logic                  srch_write;
  status_t               srch_status;
  logic [ADDR_W-1:0]     srch_addr;

  // Lowest-index free slot; the downward scan lets the smallest index win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) free_idx = ADDR_W'(i);
    end
  end

  assign all_full = &bitmap_q;

`ifdef PQSDN_CAM_MGR_DUP_CHECK_EN
  // A hit on a slot the bitmap calls free is stale CAM content, not a duplicate.
  assign dup_hit      = cam_rdvalid_i && bitmap_q[cam_rdaddr_i];
  assign cam_rden_o   = (state_q == S_SEARCH) && (op_q == OP_INSERT);
  assign cam_rddata_o = key_q;
`else
  logic unused_rd;
  assign unused_rd    = ^{cam_rdaddr_i, cam_rdvalid_i};
  assign dup_hit      = 1'b0;
  assign cam_rden_o   = 1'b0;
  assign cam_rddata_o = '0;
`endif

  // Next-state and SEARCH outcome decode.
  always_comb begin
    state_d     = state_q;
    srch_write  = 1'b0;
    srch_status = ST_OK;
    srch_addr   = '0;
    unique case (state_q)
      S_INIT:   if (init_cnt_q == INIT_LAST) state_d = S_IDLE;
      S_IDLE:   if (req_valid_i) state_d = S_SEARCH;
      S_SEARCH: begin
        if (op_q == OP_INSERT) begin
          if (key_q == EMPTY) begin
            srch_status = ST_ERR;
          end else if (dup_hit) begin
            srch_status = ST_DUP;
            srch_addr   = cam_rdaddr_i;
          end else if (all_full) begin
            srch_status = ST_FULL;
          end else begin
            srch_write  = 1'b1;
            srch_addr   = free_idx;
          end
        end else begin
          srch_addr = addr_q;
          if (!bitmap_q[addr_q]) srch_status = ST_ERR;
          else                   srch_write  = 1'b1;
        end
        state_d = srch_write ? S_WRITE : S_RESP;
      end
      S_WRITE:  state_d = S_RESP;
      S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Datapath. The bitmap is plain flop state and is cleared here; the CAM itself is
  // cleared by the INIT sweep because it cannot be reset directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      init_cnt_q   <= '0;
      op_q         <= 1'b0;
      key_q        <= '0;
      addr_q       <= '0;
      bitmap_q     <= '0;
      count_q      <= '0;
      rsp_addr_q   <= '0;
      rsp_status_q <= ST_OK;
      cam_en_q     <= 1'b0;
      cam_wraddr_q <= '0;
      cam_wrdata_q <= '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          // Writes lag the counter by one cycle, so INIT runs NUM_SLOTS+1 cycles.
          if (init_cnt_q == INIT_LAST) begin
            cam_en_q <= 1'b0;
          end else begin
            cam_en_q     <= 1'b1;
            cam_wraddr_q <= init_cnt_q[ADDR_W-1:0];
            cam_wrdata_q <= EMPTY;
            init_cnt_q   <= init_cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid_i) begin
            op_q   <= req_op_i;
            key_q  <= req_data_i;
            addr_q <= req_addr_i;
          end
        end
        S_SEARCH: begin
          rsp_addr_q   <= srch_addr;
          rsp_status_q <= srch_status;
          if (srch_write) begin
            cam_en_q     <= 1'b1;
            cam_wraddr_q <= srch_addr;
            cam_wrdata_q <= (op_q == OP_INSERT) ? key_q : EMPTY;
          end
        end
        S_WRITE: begin
          cam_en_q             <= 1'b0;
          bitmap_q[rsp_addr_q] <= (op_q == OP_INSERT);
          rsp_status_q         <= ST_OK;
          if (op_q == OP_INSERT) begin
            if (count_q != INIT_LAST) count_q <= count_q + 1'b1;
          end else begin
            if (count_q != '0) count_q <= count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_addr_o   = rsp_addr_q;
  assign rsp_status_o = rsp_status_q;
  assign cam_en_o     = cam_en_q;
  assign cam_wraddr_o = cam_wraddr_q;
  assign cam_wrdata_o = cam_wrdata_q;
  assign count_o      = count_q;

endmodule
